bcd_display_converter: RTL
==========================

// Module: bcd_display_converter
// PURPOSE
//  Sequential, parametrised binary-to-BCD converter feeding the LCD digit path.
//  Replaces the fixed 2-digit compare/subtract chain with shift-add-3 (double dabble).
//  Supports configurable width, digit count and signed/unsigned input, with a
//  start/busy/done handshake and an overflow flag.
//  Sits between the CPU register-readout mux and LCD_Controller, on the LCD clock domain.
// PARAMETERS
//  DATA_W  32  binary input width, >= 4
//  DIGITS  10  BCD digits produced, >= 1; 10 covers full 32-bit magnitude
//  SIGNED  1   1: din is two's complement, magnitude+sign; 0: din is unsigned
// PORTS
//  clk     in   1           rising-edge clock
//  reset   in   1           asynchronous, active-low reset
//  start   in   1           request conversion of din; sampled only in IDLE
//  din     in   DATA_W      binary value, captured on the accepted start
//  busy    out  1           high from the cycle after start acceptance until done
//  done    out  1           one-cycle pulse; outputs below valid from this cycle
//  sign    out  1           1 = negative input (SIGNED=1 only, else always 0)
//  bcd     out  4*DIGITS    digits, [3:0] = least significant
//  ovf     out  1           magnitude >= 10**DIGITS; bcd saturated to all 9s
//  blank   out  DIGITS      leading-zero mask, 1 = suppress (macro only)
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE; busy=0, done=0, sign=0, bcd=0, ovf=0, blank=0.
//  FSM: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
//   IDLE : start=1 -> LOAD. start=0 -> stay in IDLE.
//   LOAD : sign_r = SIGNED & din[DATA_W-1].
//          mag = sign_r ? (~din+1) : din, computed unsigned in DATA_W bits.
//          -2**(DATA_W-1) gives mag = 2**(DATA_W-1), which is correct.
//          Clear scratch BCD register and sticky ovf. Load bit counter with DATA_W. busy=1.
//   SHIFT: one bit per cycle, DATA_W cycles.
//          Each digit >= 5 gets +3, then {bcd,mag} shifts left by 1.
//          A 1 shifted out of the top digit sets sticky ovf. Counter reaches 0 -> DONE.
//   DONE : register bcd, sign and ovf. If ovf, bcd = all 4'h9. done=1, busy=0 -> IDLE.
//  Latency: start accepted at edge N; done high in the cycle after edge N+DATA_W+2.
//   Default: DATA_W+2 = 34 cycles.
//  Output hold: bcd, sign, ovf and blank hold their last result until the next DONE.
//   They are not cleared on start.
//  start while busy (LOAD/SHIFT/DONE): ignored, not queued. din changes while busy: no effect.
//  start held high: a new conversion starts on the IDLE cycle after each done.
//   Period is DATA_W+3 cycles.
//  Reset mid-conversion: immediate abort to IDLE, all outputs zero, no done pulse.
//  Zero input: bcd=0, sign=0, ovf=0.
//   SIGNED=1 with din=0 never reports -0.
// CONFIGURATION
//  BCD_LEADING_BLANK_EN defined:
//   In DONE, blank[i]=1 when digit i and every higher digit are zero, for i>=1.
//   blank[0] is always 0, so value 0 shows a single "0".
//   ovf forces blank=0.
//   LCD_Controller prints a space for blanked digits and places the sign left of the
//   first unblanked digit.
//  BCD_LEADING_BLANK_EN undefined:
//   The blank port still exists and is tied to 0. No blank logic is synthesised.
// TESTING
//  T1 DATA_W=32,DIGITS=10,SIGNED=1:
//   din=32'd42, one-cycle start -> done exactly 34 cycles later; bcd=40'h42, sign=0, ovf=0.
//  T2 din=32'hFFFFFFFF -> sign=1, bcd=40'h1.
//   din=32'h80000000 -> sign=1, bcd=40'h2147483648, ovf=0.
//  T3 DIGITS=2, SIGNED=0: din=99 -> bcd=8'h99, ovf=0.
//   din=100 -> ovf=1, bcd=8'h99.
//   din=32'hFFFFFFFF -> ovf=1.
//  T4 start pulsed again at cycle 5 of a busy conversion -> ignored.
//   Exactly one done pulse, result belongs to the first din.
//   Reset asserted mid-SHIFT -> busy=0, bcd=0, no done.
//   Next start works normally.
//  T5 BCD_LEADING_BLANK_EN, DIGITS=4: din=42 -> blank=4'b1100; din=0 -> blank=4'b1110;
//   din=1234 -> blank=4'b0000.
//   Without the macro, blank=0 for all three values.
//  T6 start held high for 200 cycles -> done every 35 cycles, busy never high with done.
//   Compare against a $display reference model for 1000 random din values.

Source files
------------

// File: rtl/bcd_display_converter.sv
// Sequential binary-to-BCD converter (shift-add-3) with start/busy/done handshake and overflow.
// Optional leading-zero blanking when BCD_LEADING_BLANK_EN is defined.

module bcd_display_converter_add3 (
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bcd_display_converter #(
   parameter int DATA_W = 32,
   parameter int DIGITS = 10,
   parameter int SIGNED = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_W-1:0]     din,
   output logic                  busy,
   output logic                  done,
   output logic                  sign,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf,
   output logic [DIGITS-1:0]     blank
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_FIN} state_t;

   state_t            state;
   logic [DATA_W-1:0] din_r;
   logic [DATA_W-1:0] mag;
   logic [BW-1:0]     scratch;
   logic [BW-1:0]     adj;
   logic              ovf_r;
   logic              sign_r;
   logic [CW-1:0]     cnt;
   logic              neg;

   assign neg = (SIGNED != 0) && din_r[DATA_W-1];

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_display_converter_add3 u_add3 (
         .d (scratch[4*g +: 4]),
         .q (adj[4*g +: 4])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         sign    <= 1'b0;
         bcd     <= '0;
         ovf     <= 1'b0;
         din_r   <= '0;
         mag     <= '0;
         scratch <= '0;
         ovf_r   <= 1'b0;
         sign_r  <= 1'b0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  din_r <= din;
                  busy  <= 1'b1;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               // most-negative input wraps to 2**(DATA_W-1), which is the true magnitude
               sign_r  <= neg;
               mag     <= neg ? (~din_r + DATA_W'(1)) : din_r;
               scratch <= '0;
               ovf_r   <= 1'b0;
               cnt     <= CW'(DATA_W);
               state   <= S_SHIFT;
            end
            S_SHIFT: begin
               // a 1 leaving the top digit means the magnitude cannot fit in DIGITS digits
               scratch <= {adj[BW-2:0], mag[DATA_W-1]};
               mag     <= {mag[DATA_W-2:0], 1'b0};
               ovf_r   <= ovf_r | adj[BW-1];
               cnt     <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= S_FIN;
            end
            S_FIN: begin
               bcd   <= ovf_r ? {DIGITS{4'h9}} : scratch;
               sign  <= sign_r;
               ovf   <= ovf_r;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef BCD_LEADING_BLANK_EN
   logic [DIGITS-1:0] blank_nxt;

   // digit 0 is never blanked so a zero result still shows one "0"
   always_comb begin
      logic all_zero;
      blank_nxt = '0;
      all_zero  = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         all_zero     = all_zero & (scratch[4*i +: 4] == 4'd0);
         blank_nxt[i] = all_zero & ~ovf_r;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                blank <= '0;
      else if (state == S_FIN)   blank <= blank_nxt;
   end
`else
   assign blank = '0;
`endif

endmodule
